q_8_34a: RTL and testbench
==========================

# q_8_34a

Datapath of a ones-counter: counts the 1 bits in a data word under control of an external controller. Holds operand register R1, count register R2 and the shift-out flip-flop E. Reports status (zero, E) back to the controller. Algorithm: load, pre-increment R2 so it reads 0, then repeatedly shift R1 left into E and increment R2 whenever E=1, until R1 is zero.

## Interface
- data_size, default 4 (from q_8_34a_pkg): width of data_in, R1 and R2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_b  input  1  reset; asynchronous, active-high (rst_b=1 resets).
- data_in  input  data_size  word whose 1 bits are counted.
- load_regs  input  1  load R1 from data_in, preset R2 to all ones.
- incr_r2  input  1  increment R2.
- shift  input  1  shift {E,R1} left by one.
- zero  output  1  high when R1 == 0; combinational.
- E  output  1  shift-out flip-flop (last MSB shifted out of R1).

Internal registers R1[data_size-1:0] and R2[data_size-1:0] keep these names so the bench can probe them hierarchically.

## Operation
- Reset (rst_b=1, any time, independent of clk): R1=0, R2=0, E=0; therefore zero=1.
- load_regs=1 at a clock edge:
  - R1 <= data_in
  - R2 <= all ones
  - E <= 0
  - incr_r2 and shift are ignored that cycle (load has priority).
- shift=1 (and load_regs=0): E <= R1[data_size-1]; R1 <= {R1[data_size-2:0], 1'b0}.
- incr_r2=1 (and load_regs=0): R2 <= R2 + 1, modulo 2^data_size. All ones wraps to 0, which is the intended pre-increment after load.
- shift and incr_r2 both high (load_regs=0): both actions occur in the same edge, each independently as above.
- No control asserted: R1, R2 and E hold.
- zero = ~|R1; it depends only on R1, not on R2 or E.
- After a full count (load, one incr, then repeated shift with incr whenever E=1, stopping when zero=1), R2 equals the popcount of the loaded word.

## Timing
- All register updates occur on the rising clk edge; outputs are visible in the same cycle after the edge.
- Control inputs are sampled on the edge and have one-cycle latency to R1, R2 and E.
- zero is combinational from R1, so it updates the same cycle R1 changes; no extra latency.
- E is registered.
- Asynchronous reset overrides any in-progress sequence immediately. After reset deasserts, the next edge with controls applies normally.
- Controls are level-sensitive: each edge with a control high performs one action, so a control held for N cycles performs N actions.

## Test plan
- Reset: assert rst_b=1 mid-sequence -> R1=0, R2=0, E=0, zero=1 immediately, without a clock edge.
- Load: data_in=4'b1010, load_regs for 1 cycle -> R1=1010, R2=1111, E=0, zero=0.
- Increment: after the load, incr_r2 for 1 cycle -> R2=0000 (wrap).
- Shift: shift for 1 cycle -> R1=0100, E=1, zero=0. Then incr_r2 -> R2=0001.
- Full count of 1010:
  - shift -> R1=1000, E=0.
  - shift -> R1=0000, E=1, zero=1.
  - incr -> R2=0010 (popcount 2).
- Priority and simultaneous controls:
  - load_regs with shift and incr_r2 all high -> load result only.
  - With R1=1001, R2=0011, shift and incr_r2 together -> R1=0010, E=1, R2=0100.
  - Load data_in=0 -> zero=1.

Source files
------------

// File: rtl/q_8_34a.sv
// Ones-counter datapath: operand register R1, count register R2 and the
// shift-out flip-flop E, plus the zero status fed back to the controller.
// The controller sequences load / pre-increment / shift / conditional
// increment; this block only performs the register actions it is told to.

package q_8_34a_pkg;
    parameter int data_size = 4;
endpackage

module q_8_34a
    import q_8_34a_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic [data_size-1:0] data_in,
    input  logic                 load_regs,
    input  logic                 incr_r2,
    input  logic                 shift,
    output logic                 zero,
    output logic                 E
);

    // After load R2 holds all ones so the first increment wraps it to zero.
    localparam logic [data_size-1:0] r2_preset_c = {data_size{1'b1}};
    localparam logic [data_size-1:0] r2_step_c   = {{(data_size-1){1'b0}}, 1'b1};
    localparam logic [data_size-1:0] clear_c     = {data_size{1'b0}};

    logic [data_size-1:0] R1;
    logic [data_size-1:0] R2;

    // Operand register and shift-out bit: load wins, otherwise shift {E,R1} left.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            R1 <= clear_c;
            E  <= 1'b0;
        end else if (load_regs) begin
            R1 <= data_in;
            E  <= 1'b0;
        end else if (shift) begin
            E  <= R1[data_size-1];
            R1 <= {R1[data_size-2:0], 1'b0};
        end else begin
            R1 <= R1;
            E  <= E;
        end
    end

    // Count register: preset on load, otherwise increment modulo 2^data_size.
    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            R2 <= clear_c;
        end else if (load_regs) begin
            R2 <= r2_preset_c;
        end else if (incr_r2) begin
            R2 <= R2 + r2_step_c;
        end else begin
            R2 <= R2;
        end
    end

    // Status to the controller: operand exhausted, independent of R2 and E.
    always_comb begin
        zero = ~|R1;
    end

endmodule

// File: tb/tb_q_8_34a.sv
// Bench for the ones-counter datapath: a table of single-cycle control
// vectors checked through an expected-value queue, plus hand-written
// reset and full-count sequences.

module tb_q_8_34a;
    import q_8_34a_pkg::*;

    logic                 clk;
    logic                 rst_b;
    logic [data_size-1:0] data_in;
    logic                 load_regs;
    logic                 incr_r2;
    logic                 shift;
    logic                 zero;
    logic                 E;

    int pass_cnt;
    int total_cnt;

    q_8_34a dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .data_in   (data_in),
        .load_regs (load_regs),
        .incr_r2   (incr_r2),
        .shift     (shift),
        .zero      (zero),
        .E         (E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       ld;
        logic       inc;
        logic       sh;
        logic [3:0] din;
        logic [3:0] r1;
        logic [3:0] r2;
        logic       e;
        logic       z;
    } vec_t;

    typedef struct packed {
        logic [3:0] r1;
        logic [3:0] r2;
        logic       e;
        logic       z;
    } exp_t;

    vec_t vecs [19];
    exp_t sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic ld, input logic inc, input logic sh, input logic [3:0] din);
        load_regs = ld;
        incr_r2   = inc;
        shift     = sh;
        data_in   = din;
    endtask

    // One clock, then sample away from the edge and release the controls.
    task automatic tick();
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    function automatic logic [9:0] state_now();
        return {dut.R1, dut.R2, E, zero};
    endfunction

    // Run the controller algorithm on word w and compare R2 with its popcount.
    task automatic full_count(input logic [3:0] w);
        int  budget;
        exp_t ex;
        drive(1'b1, 1'b0, 1'b0, w);
        tick();
        drive(1'b0, 1'b1, 1'b0, 4'b0000);
        tick();
        budget = 0;
        while (zero !== 1'b1 && budget < 20) begin
            drive(1'b0, 1'b0, 1'b1, 4'b0000);
            tick();
            if (E === 1'b1) begin
                drive(1'b0, 1'b1, 1'b0, 4'b0000);
                tick();
            end
            budget++;
        end
        if (budget >= 20) check($sformatf("count_timeout_%b", w), 32'd0, 32'd1);
        ex.r1 = 4'b0000;
        ex.r2 = 4'($countones(w));
        ex.e  = E === 1'b1 ? 1'b1 : 1'b0;
        ex.z  = 1'b1;
        check($sformatf("popcount_%b", w), {22'd0, dut.R1, dut.R2, 1'b0, zero},
              {22'd0, ex.r1, ex.r2, 1'b0, ex.z});
    endtask

    initial begin
        exp_t ex;
        logic [3:0] w;
        pass_cnt  = 0;
        total_cnt = 0;

        //           ld    inc   sh    din      r1       r2       e     z
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b1010, 4'b1010, 4'b1111, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1010, 4'b0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0100, 4'b0001, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b1000, 4'b0001, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'b0101, 4'b0000, 4'b0010, 1'b1, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 4'b0110, 4'b0110, 4'b1111, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'b1001, 4'b1001, 4'b1111, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1001, 4'b0000, 1'b0, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1001, 4'b0001, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1001, 4'b0010, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 4'b0000, 4'b1001, 4'b0011, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0010, 4'b0100, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 4'b0000, 4'b0100, 4'b0100, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b1};

        // Reset asserted before any clock edge.
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        rst_b = 1'b1;
        #2;
        check("reset_initial", {22'd0, state_now()}, {22'd0, 4'b0000, 4'b0000, 1'b0, 1'b1});
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1;

        // Table vectors: expectation queued when the stimulus is driven.
        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].ld, vecs[i].inc, vecs[i].sh, vecs[i].din);
            sb_q.push_back('{vecs[i].r1, vecs[i].r2, vecs[i].e, vecs[i].z});
            tick();
            if (sb_q.size() == 0) begin
                check($sformatf("vec%0d_queue_empty", i), 32'd0, 32'd1);
            end else begin
                ex = sb_q.pop_front();
                check($sformatf("vec%0d", i), {22'd0, state_now()}, {22'd0, ex});
            end
        end

        // Reset mid-sequence takes effect without a clock edge.
        drive(1'b1, 1'b0, 1'b0, 4'b1011);
        tick();
        drive(1'b0, 1'b1, 1'b1, 4'b0000);
        tick();
        check("pre_reset_state", {22'd0, state_now()}, {22'd0, 4'b0110, 4'b0000, 1'b1, 1'b0});
        #1;
        rst_b = 1'b1;
        #1;
        check("reset_async", {22'd0, state_now()}, {22'd0, 4'b0000, 4'b0000, 1'b0, 1'b1});
        @(negedge clk);
        rst_b = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 4'b0011);
        tick();
        check("load_after_reset", {22'd0, state_now()}, {22'd0, 4'b0011, 4'b1111, 1'b0, 1'b0});

        // Held control performs one action per edge.
        drive(1'b0, 1'b0, 1'b1, 4'b0000);
        @(posedge clk);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, 4'b0000);
        check("shift_held_2", {22'd0, state_now()}, {22'd0, 4'b1100, 4'b1111, 1'b0, 1'b0});

        // Full counts, fixed corners then random words.
        full_count(4'b1010);
        full_count(4'b0000);
        full_count(4'b1111);
        full_count(4'b0001);
        full_count(4'b1000);
        for (int k = 0; k < 6; k++) begin
            w = 4'($urandom_range(0, 15));
            full_count(w);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
